// File: rtl/code_pkg.sv
// Shared definitions for the tooth-period monitor.
// Contents: FSM state encoding, data/address widths, default parameter values,
// saturating adder and tolerance-compare helpers.
package code_pkg;

    localparam int unsigned CODE_W          = 32;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned IDLE_W          = 23;
    localparam int unsigned DEF_TOOTH_NUM   = 179;
    localparam int unsigned DEF_TOL_SHIFT   = 6;
    localparam int unsigned DEF_STABLE_REVS = 4;
    localparam int unsigned DEF_TIMEOUT     = 5_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } code_state_t;

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        logic [CODE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CODE_W] ? {CODE_W{1'b1}} : s[CODE_W-1:0];
    endfunction

    // |cur - prev| <= prev >> shift
    function automatic logic within_tol(input logic [CODE_W-1:0] cur,
                                        input logic [CODE_W-1:0] prev,
                                        input int unsigned       shift);
        logic [CODE_W-1:0] diff;
        diff = (cur >= prev) ? (cur - prev) : (prev - cur);
        return diff <= (prev >> shift);
    endfunction

endpackage

// File: rtl/code_period_monitor_if.sv
// Tooth-period write stream from the encoder generator.
//   wren   : write strobe
//   wraddr : tooth index, 0 = zero-gap write closing the revolution
//   wrdata : tooth period in clock cycles
// master = encoder generator side, slave = monitor side.
interface code_period_monitor_if;
    import code_pkg::*;

    logic              wren;
    logic [ADDR_W-1:0] wraddr;
    logic [CODE_W-1:0] wrdata;

    modport master (output wren, wraddr, wrdata);
    modport slave  (input  wren, wraddr, wrdata);

endinterface

// File: rtl/code_period_ram.sv
// Two-bank 256x32 simple dual-port RAM; bank is the address MSB.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read port, registered (1-cycle latency)
module code_period_ram
    import code_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/code_period_monitor.sv
// Per-revolution tooth-period monitor.
// Buffers one revolution of tooth periods in a ping-pong RAM, checks tooth count and
// revolution period against the previous revolution, flags stable speed or stall timeout.
// Optional macro CODE_MINMAX_EN: track per-revolution min/max tooth period.
// Ports:
//   i_clk_50m, i_rst    : clock, synchronous active-high reset
//   i_motor_state       : 1 = motor running
//   code_if (slave)     : tooth-period write stream
//   i_rd_addr/o_rd_data : host read of the inactive bank, 1-cycle latency
//   o_bank_sel          : bank currently being written
//   o_rev_valid         : 1-cycle pulse, revolution results updated
//   o_rev_period/o_tooth_cnt/o_tooth_err : last complete revolution results
//   o_speed_stable, o_timeout            : status flags
//   o_per_min/o_per_max : min/max tooth period of last revolution (0 when disabled)
module code_period_monitor
    import code_pkg::*;
#(
    parameter int unsigned P_TOOTH_NUM   = DEF_TOOTH_NUM,
    parameter int unsigned P_TOL_SHIFT   = DEF_TOL_SHIFT,
    parameter int unsigned P_STABLE_REVS = DEF_STABLE_REVS,
    parameter int unsigned P_TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  i_clk_50m,
    input  logic                  i_rst,
    input  logic                  i_motor_state,
    code_period_monitor_if.slave  code_if,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [CODE_W-1:0]     o_rd_data,
    output logic                  o_bank_sel,
    output logic                  o_rev_valid,
    output logic [CODE_W-1:0]     o_rev_period,
    output logic [ADDR_W-1:0]     o_tooth_cnt,
    output logic                  o_tooth_err,
    output logic                  o_speed_stable,
    output logic                  o_timeout,
    output logic [CODE_W-1:0]     o_per_min,
    output logic [CODE_W-1:0]     o_per_max
);

    localparam int unsigned STAB_W = $clog2(P_STABLE_REVS + 1);

    code_state_t       state;
    logic [CODE_W-1:0] sum_acc, snap_sum, prev_period;
    logic [ADDR_W-1:0] cnt_acc, snap_cnt;
    logic              have_prev;
    logic [STAB_W-1:0] stable_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic              addr_zero, in_run, sync_start, rev_close, acc_wr, ram_we;
    logic              timeout_hit, rev_good;
    logic [CODE_W-1:0] sum_next;
    logic [ADDR_W-1:0] cnt_next;
    logic [STAB_W-1:0] stable_inc;

    assign addr_zero  = (code_if.wraddr == '0);
    assign in_run     = (state == ST_ACC) || (state == ST_DONE);
    assign sync_start = code_if.wren && (state == ST_SYNC) && addr_zero;
    assign rev_close  = code_if.wren && (state == ST_ACC) && addr_zero;
    // A wren in ST_DONE belongs to the new revolution, whatever its address.
    assign acc_wr     = code_if.wren && (((state == ST_ACC) && !addr_zero) ||
                                         (state == ST_DONE));
    assign ram_we     = code_if.wren && in_run && i_motor_state && !i_rst;

    assign sum_next   = sat_add(sum_acc, code_if.wrdata);
    assign cnt_next   = (cnt_acc == '1) ? cnt_acc : cnt_acc + 1'b1;
    assign timeout_hit = !code_if.wren && (idle_cnt == IDLE_W'(P_TIMEOUT - 1));
    // The first revolution after resync has no reference period.
    assign rev_good   = (snap_cnt == ADDR_W'(P_TOOTH_NUM)) &&
                        (!have_prev || within_tol(snap_sum, prev_period, P_TOL_SHIFT));
    assign stable_inc = (stable_cnt == STAB_W'(P_STABLE_REVS)) ? stable_cnt
                                                               : stable_cnt + 1'b1;

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            o_bank_sel     <= 1'b0;
            o_rev_valid    <= 1'b0;
            o_rev_period   <= '0;
            o_tooth_cnt    <= '0;
            o_tooth_err    <= 1'b0;
            o_speed_stable <= 1'b0;
            o_timeout      <= 1'b0;
            sum_acc        <= '0;
            cnt_acc        <= '0;
            snap_sum       <= '0;
            snap_cnt       <= '0;
            prev_period    <= '0;
            have_prev      <= 1'b0;
            stable_cnt     <= '0;
            idle_cnt       <= '0;
        end else if (!i_motor_state) begin
            // Last results, prev period's bank and RAM content are kept.
            state          <= ST_IDLE;
            o_rev_valid    <= 1'b0;
            o_speed_stable <= 1'b0;
            o_timeout      <= 1'b0;
            sum_acc        <= '0;
            cnt_acc        <= '0;
            have_prev      <= 1'b0;
            stable_cnt     <= '0;
            idle_cnt       <= '0;
        end else begin
            o_rev_valid <= 1'b0;
            if (in_run) begin
                idle_cnt <= code_if.wren ? '0 : idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
            if (acc_wr) begin
                sum_acc <= sum_next;
                cnt_acc <= cnt_next;
            end

            unique case (state)
                ST_IDLE: begin
                    have_prev <= 1'b0;
                    state     <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (code_if.wren) begin
                        o_timeout <= 1'b0;
                    end
                    if (sync_start) begin
                        sum_acc <= '0;
                        cnt_acc <= '0;
                        state   <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (rev_close) begin
                        snap_sum   <= sum_next;
                        snap_cnt   <= cnt_next;
                        sum_acc    <= '0;
                        cnt_acc    <= '0;
                        o_bank_sel <= ~o_bank_sel;
                        state      <= ST_DONE;
                    end else if (timeout_hit) begin
                        o_timeout      <= 1'b1;
                        o_speed_stable <= 1'b0;
                        stable_cnt     <= '0;
                        have_prev      <= 1'b0;
                        state          <= ST_SYNC;
                    end
                end
                ST_DONE: begin
                    o_rev_valid  <= 1'b1;
                    o_rev_period <= snap_sum;
                    o_tooth_cnt  <= snap_cnt;
                    o_tooth_err  <= (snap_cnt != ADDR_W'(P_TOOTH_NUM));
                    prev_period  <= snap_sum;
                    have_prev    <= 1'b1;
                    if (rev_good) begin
                        stable_cnt     <= stable_inc;
                        o_speed_stable <= (stable_inc == STAB_W'(P_STABLE_REVS));
                    end else begin
                        stable_cnt     <= '0;
                        o_speed_stable <= 1'b0;
                    end
                    state <= ST_ACC;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CODE_MINMAX_EN
    logic [CODE_W-1:0] min_acc, max_acc, snap_min, snap_max;

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            min_acc   <= '1;
            max_acc   <= '0;
            snap_min  <= '0;
            snap_max  <= '0;
            o_per_min <= '0;
            o_per_max <= '0;
        end else if (!i_motor_state || sync_start) begin
            min_acc <= '1;
            max_acc <= '0;
        end else begin
            if (rev_close) begin
                snap_min <= min_acc;
                snap_max <= max_acc;
                min_acc  <= '1;
                max_acc  <= '0;
            end else if (acc_wr && !addr_zero) begin
                // Gap write is excluded from min/max.
                if (code_if.wrdata < min_acc) min_acc <= code_if.wrdata;
                if (code_if.wrdata > max_acc) max_acc <= code_if.wrdata;
            end
            if (state == ST_DONE) begin
                o_per_min <= snap_min;
                o_per_max <= snap_max;
            end
        end
    end
`else
    assign o_per_min = '0;
    assign o_per_max = '0;
`endif

    code_period_ram u_ram (
        .clk   (i_clk_50m),
        .rst   (i_rst),
        .we    (ram_we),
        .waddr ({o_bank_sel, code_if.wraddr}),
        .wdata (code_if.wrdata),
        .raddr ({~o_bank_sel, i_rd_addr}),
        .rdata (o_rd_data)
    );

endmodule

// File: tb/tb_code_period_monitor.sv
// Directed bench for code_period_monitor: table of revolutions plus hand sequences for
// bank readout, stall timeout, motor stop, min/max and reset.
module tb_code_period_monitor;
    import code_pkg::*;

    localparam int unsigned P_TO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        motor;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data, rev_period, per_min, per_max;
    logic        bank_sel, rev_valid, tooth_err, speed_stable, timeout;
    logic [7:0]  tooth_cnt;

    int n_pass = 0;
    int n_total = 0;
    int step = 0;

    code_period_monitor_if wif ();

    code_period_monitor #(
        .P_TIMEOUT (P_TO)
    ) dut (
        .i_clk_50m      (clk),
        .i_rst          (rst),
        .i_motor_state  (motor),
        .code_if        (wif),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_bank_sel     (bank_sel),
        .o_rev_valid    (rev_valid),
        .o_rev_period   (rev_period),
        .o_tooth_cnt    (tooth_cnt),
        .o_tooth_err    (tooth_err),
        .o_speed_stable (speed_stable),
        .o_timeout      (timeout),
        .o_per_min      (per_min),
        .o_per_max      (per_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          teeth;
        logic [31:0] period;
        logic [31:0] poke5;
        logic        exp_valid;
        logic [31:0] exp_period;
        logic [7:0]  exp_cnt;
        logic        exp_err;
        logic        exp_stable;
        logic [31:0] exp_min;
        logic [31:0] exp_max;
    } rev_vec_t;

    rev_vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %0d, want %0d", name, step, act, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wif.wren   = 1'b1;
        wif.wraddr = a;
        wif.wrdata = d;
        @(posedge clk); #1;
        wif.wren   = 1'b0;
    endtask

    task automatic chk_minmax(input logic [31:0] mn, input logic [31:0] mx);
`ifdef CODE_MINMAX_EN
        chk("per_min", per_min, mn);
        chk("per_max", per_max, mx);
`else
        chk("per_min", per_min, mn & 32'd0);
        chk("per_max", per_max, mx & 32'd0);
`endif
    endtask

    task automatic do_rev(input rev_vec_t v);
        for (int a = 1; a < v.teeth; a++) begin
            wr(8'(a), (a == 5 && v.poke5 != 0) ? v.poke5 : v.period);
        end
        wr(8'd0, v.period);
        chk("valid_early", rev_valid, 0);
        @(posedge clk); #1;
        chk("rev_valid", rev_valid, v.exp_valid);
        chk("speed_stable", speed_stable, v.exp_stable);
        if (v.exp_valid) begin
            chk("rev_period", rev_period, v.exp_period);
            chk("tooth_cnt", tooth_cnt, v.exp_cnt);
            chk("tooth_err", tooth_err, v.exp_err);
            chk_minmax(v.exp_min, v.exp_max);
            @(posedge clk); #1;
            chk("valid_pulse", rev_valid, 0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_rev_valid", rev_valid, 0);
        chk("rst_rev_period", rev_period, 0);
        chk("rst_tooth_cnt", tooth_cnt, 0);
        chk("rst_tooth_err", tooth_err, 0);
        chk("rst_stable", speed_stable, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_per_min", per_min, 0);
        chk("rst_per_max", per_max, 0);
    endtask

    initial begin
        int n;
        tbl[0]  = '{179, 1000,   0, 0,      0,   0, 0, 0,    0,    0};
        tbl[1]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[2]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[3]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[4]  = '{179, 1000,   0, 1, 179000, 179, 0, 1, 1000, 1000};
        tbl[5]  = '{177, 1000,   0, 1, 177000, 177, 1, 0, 1000, 1000};
        tbl[6]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[7]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[8]  = '{179, 1000,   0, 1, 179000, 179, 0, 0, 1000, 1000};
        tbl[9]  = '{179, 1000,   0, 1, 179000, 179, 0, 1, 1000, 1000};
        tbl[10] = '{179, 1020,   0, 1, 182580, 179, 0, 0, 1020, 1020};
        tbl[11] = '{179, 1020,   0, 1, 182580, 179, 0, 0, 1020, 1020};
        tbl[12] = '{179, 1020,   0, 1, 182580, 179, 0, 0, 1020, 1020};
        tbl[13] = '{179, 1020,   0, 1, 182580, 179, 0, 0, 1020, 1020};
        tbl[14] = '{179, 1020,   0, 1, 182580, 179, 0, 1, 1020, 1020};
        tbl[15] = '{179, 1020, 777, 1, 182337, 179, 0, 1,  777, 1020};

        rst = 1'b1; motor = 1'b0; rd_addr = 8'd0;
        wif.wren = 1'b0; wif.wraddr = 8'd0; wif.wrdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;
        motor = 1'b1;

        // Steady, short rev, +2 % step, and a rev with addr 5 poked.
        for (int i = 0; i < 16; i++) begin
            step = i;
            do_rev(tbl[i]);
        end

        // Host readout of the inactive bank, undisturbed by writes to the active one.
        step = 100;
        chk("bank_sel_after_15", bank_sel, 1);
        rd_addr = 8'd5;
        @(posedge clk); #1;
        chk("rd_addr5", rd_data, 777);
        for (int a = 1; a <= 10; a++) wr(8'(a), 1020);
        chk("rd_during_wr", rd_data, 777);
        for (int a = 11; a <= 178; a++) wr(8'(a), 1020);
        wr(8'd0, 1020);
        chk("bank_swapped", bank_sel, 0);
        chk("rd_pre_swap", rd_data, 777);
        @(posedge clk); #1;
        chk("rev_valid_rd", rev_valid, 1);
        chk("rev_period_rd", rev_period, 182580);
        chk("rd_post_swap", rd_data, 1020);
        chk("stable_before_to", speed_stable, 1);

        // Stall in ST_ACC.
        step = 200;
        n = 0;
        for (int i = 0; i < int'(P_TO) + 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (timeout) break;
        end
        chk("timeout_set", timeout, 1);
        chk("timeout_latency", (n >= int'(P_TO) - 10) && (n <= int'(P_TO)), 1);
        chk("stable_after_to", speed_stable, 0);
        wr(8'd0, 1000);
        chk("timeout_cleared", timeout, 0);
        @(posedge clk); #1;
        chk("no_valid_resync", rev_valid, 0);
        // Prev period dropped on resync: 179000 vs old 182580 still counts as good.
        step = 201;
        do_rev('{179, 1000, 0, 1, 179000, 179, 0, 0, 1000, 1000});
        for (int i = 0; i < 3; i++) begin
            step = 202 + i;
            do_rev('{179, 1000, 0, 1, 179000, 179, 0, (i == 2), 1000, 1000});
        end

        // Motor stop mid-rev.
        step = 300;
        for (int a = 1; a <= 50; a++) wr(8'(a), 1000);
        motor = 1'b0;
        @(posedge clk); #1;
        chk("off_stable", speed_stable, 0);
        chk("off_timeout", timeout, 0);
        chk("off_valid", rev_valid, 0);
        chk("off_rev_period_kept", rev_period, 179000);
        chk("off_tooth_cnt_kept", tooth_cnt, 179);
        motor = 1'b1;
        step = 301;
        do_rev('{179, 1000, 0, 0, 0, 0, 0, 0, 0, 0});

        // Min/max spread; gap write of 5 must not become the minimum.
        step = 400;
        wr(8'd1, 1100);
        wr(8'd2, 900);
        for (int a = 3; a <= 178; a++) wr(8'(a), 1000);
        wr(8'd0, 5);
        @(posedge clk); #1;
        chk("mm_valid", rev_valid, 1);
        chk("mm_period", rev_period, 178005);
        chk("mm_cnt", tooth_cnt, 179);
        chk("mm_err", tooth_err, 0);
        chk_minmax(900, 1100);

        // Reset mid-rev.
        step = 500;
        for (int a = 1; a <= 20; a++) wr(8'(a), 1000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_state();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
